// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;
    localparam int NRD_DEF  = 2;

    // Index width for a file of n registers; never narrower than one bit.
    function automatic int aw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for pending multi-cycle writebacks.
// A reservation landing on the same edge as a writeback to the same
// register wins, so the register stays busy for the new producer.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NRD  = NRD_DEF,
    parameter int AW   = aw_of(NREG_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    input  logic              clr_en,
    input  logic [AW-1:0]     clr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREG-1:0] busy;

    // Clear on writeback, then set on reservation; the later NBA gives set priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (clr_en) busy[clr_addr] <= 1'b0;
            if (set_en) busy[set_addr] <= 1'b1;
        end
    end

    genvar p;
    generate
        for (p = 0; p < NRD; p++) begin : g_lookup
            assign rd_busy[p] = busy[rd_addr[p*AW +: AW]];
        end
    endgenerate

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a post-reset clear
// sweep and a busy scoreboard. Define REGFILE_BYPASS_EN to forward the
// in-flight write to same-cycle readers of the same register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN     = XLEN_DEF,
    parameter  int NREG     = NREG_DEF,
    parameter  int NRD      = NRD_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = aw_of(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                init_done,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy
);

    rf_state_t        state;
    logic [AW-1:0]    idx;
    logic [XLEN-1:0]  mem [NREG];
    logic             ready;
    logic             wr_ok;
    logic             rsv_ok;
    logic             flush;
    logic [NRD-1:0]   sb_busy;

    assign ready     = (state == READY);
    assign init_done = ready;
    assign wr_ok     = ready && wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok    = ready && rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));
    // A fresh sweep discards any outstanding reservations with the old contents.
    assign flush     = ready && clr_req;

    // Clear sequencer: walk idx over every entry, then sit in READY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    if (idx == AW'(NREG - 1)) begin
                        state <= READY;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                READY: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= CLEAR;
                    idx   <= '0;
                end
            endcase
        end
    end

    // Storage is not reset so it can map to RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) mem[idx] <= '0;
        else if (wr_ok)     mem[wr_addr] <= wr_data;
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .set_en   (rsv_ok),
        .set_addr (rsv_addr),
        .clr_en   (wr_ok),
        .clr_addr (wr_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (sb_busy)
    );

    genvar p;
    generate
        for (p = 0; p < NRD; p++) begin : g_rd
            logic [AW-1:0] a;
            logic          zero;
            logic          hit;
            assign a    = rd_addr[p*AW +: AW];
            assign zero = (ZERO_REG != 0) && (a == '0);
`ifdef REGFILE_BYPASS_EN
            assign hit  = wr_ok && (a == wr_addr);
`else
            assign hit  = 1'b0;
`endif
            assign rd_data[p*XLEN +: XLEN] = (!ready || zero) ? '0 :
                                             hit ? wr_data : mem[a];
            assign rd_busy[p] = (!ready || zero) ? 1'b0 :
                                hit ? (rsv_ok && (rsv_addr == a)) : sb_busy[p];
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default 32x64x2 instance plus a 16x32x4 one.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst = 1'b1;

    // default instance
    logic         clr_req = 1'b0;
    logic         init_done;
    logic         wr_en = 1'b0;
    logic [4:0]   wr_addr = '0;
    logic [63:0]  wr_data = '0;
    logic         rsv_en = 1'b0;
    logic [4:0]   rsv_addr = '0;
    logic [9:0]   rd_addr = '0;
    logic [127:0] rd_data;
    logic [1:0]   rd_busy;

    // narrow 4-port instance
    logic         b_clr_req = 1'b0;
    logic         b_init_done;
    logic         b_wr_en = 1'b0;
    logic [3:0]   b_wr_addr = '0;
    logic [31:0]  b_wr_data = '0;
    logic         b_rsv_en = 1'b0;
    logic [3:0]   b_rsv_addr = '0;
    logic [15:0]  b_rd_addr = '0;
    logic [127:0] b_rd_data;
    logic [3:0]   b_rd_busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    regfile_mp u_dut (
        .clk(clk), .rst(rst), .clr_req(clr_req), .init_done(init_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy)
    );

    regfile_mp #(.XLEN(32), .NREG(16), .NRD(4), .ZERO_REG(1)) u_dut4 (
        .clk(clk), .rst(rst), .clr_req(b_clr_req), .init_done(b_init_done),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rsv_en(b_rsv_en), .rsv_addr(b_rsv_addr),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int port, input logic [4:0] a);
        rd_addr[port*5 +: 5] = a;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [63:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    // Count edges until init_done is seen, bounded.
    task automatic wait_init(input string tag, input int exp);
        int cnt;
        cnt = 0;
        while (!init_done && cnt < 100) begin
            tick();
            cnt++;
        end
        chk(tag, 64'(cnt), 64'(exp));
    endtask

    logic [63:0] exp3;
    logic [63:0] expb;

    initial begin
        // reset state, with a write held on reg 5 throughout
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hAAAA_5555_AAAA_5555;
        #12;
        chk("rst_init_done", {63'b0, init_done}, 64'd0);
        chk("rst_rd_data", rd_data[63:0], 64'd0);
        chk("rst_rd_busy", {62'b0, rd_busy}, 64'd0);
        tick();
        rst = 1'b0;
        wait_init("init_cycles", 32);
        wr_en = 1'b0;
        // all registers zero, reg 5 write dropped
        begin
            int bad;
            bad = 0;
            for (int a = 0; a < 32; a++) begin
                rd(0, 5'(a));
                if (rd_data[63:0] !== 64'd0) bad++;
            end
            chk("sweep_all_zero", 64'(bad), 64'd0);
        end
        rd(1, 5'd5);
        chk("reg5_dropped", rd_data[127:64], 64'd0);

        // plain write and zero register
        wr(5'd7, 64'hDEAD_BEEF_0000_0001);
        rd(1, 5'd7);
        chk("reg7_p1", rd_data[127:64], 64'hDEAD_BEEF_0000_0001);
        wr(5'd0, 64'hFF);
        rd(0, 5'd0);
        chk("reg0_zero", rd_data[63:0], 64'd0);

        // reservation lifetime on reg 9
        rd(0, 5'd9);
        chk("busy9_pre", {62'b0, rd_busy}, 64'd0);
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_en = 1'b0;
        #1;
        chk("busy9_c1", 64'(rd_busy[0]), 64'd1);
        tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 64'h9;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("busy9_c2", 64'(rd_busy[0]), 64'd0);
`else
        chk("busy9_c2", 64'(rd_busy[0]), 64'd1);
`endif
        tick();
        wr_en = 1'b0;
        #1;
        chk("busy9_done", 64'(rd_busy[0]), 64'd0);
        chk("reg9_data", rd_data[63:0], 64'h9);
        // simultaneous reservation and write
        rsv_en = 1'b1; rsv_addr = 5'd9;
        wr(5'd9, 64'h99);
        rsv_en = 1'b0;
        #1;
        chk("busy9_simul", 64'(rd_busy[0]), 64'd1);
        chk("reg9_simul", rd_data[63:0], 64'h99);
        wr(5'd9, 64'h999);
        #1;
        chk("busy9_clear", 64'(rd_busy[0]), 64'd0);

        // same-cycle write/read of reg 3
        wr(5'd3, 64'h11);
        rd(0, 5'd3);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp3 = 64'h55;
`else
        exp3 = 64'h11;
`endif
        chk("reg3_same", rd_data[63:0], exp3);
        tick();
        wr_en = 1'b0;
        #1;
        chk("reg3_after", rd_data[63:0], 64'h55);

        // 4-port instance
        chk("b_init_done", 64'(b_init_done), 64'd1);
        for (int i = 0; i < 4; i++) begin
            b_wr_en = 1'b1;
            b_wr_addr = (i == 3) ? 4'd15 : 4'(i + 1);
            b_wr_data = 32'h1111_0000 + 32'(i * 16 + 1);
            tick();
        end
        b_wr_en = 1'b0;
        b_rd_addr = {4'd15, 4'd3, 4'd2, 4'd1};
        #1;
        for (int p = 0; p < 4; p++) begin
            expb = 64'(32'h1111_0000 + 32'(p * 16 + 1));
            chk($sformatf("b_port%0d", p), 64'(b_rd_data[p*32 +: 32]), expb);
        end

        // clear sweep on request
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_drop", 64'(init_done), 64'd0);
        wait_init("clr_cycles", 32);
        rd(0, 5'd7);
        rd(1, 5'd3);
        chk("clr_reg7", rd_data[63:0], 64'd0);
        chk("clr_reg3", rd_data[127:64], 64'd0);

        // reset pulse at sweep idx 10
        wr(5'd7, 64'h77);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        #2;
        chk("rst_mid_busy", 64'(rd_busy), 64'd0);
        rst = 1'b0;
        wait_init("rst_mid_cycles", 32);
        chk("rst_mid_reg7", rd_data[63:0], 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
